// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes,
// controller state encodings, the default data width and small op decoders.
package mdu_pkg;

  localparam int DWL_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Divide operations have the upper op bit set.
  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  // The non-"U" variants are the signed ones.
  function automatic logic op_is_signed(input op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_datapath.sv
// Iterative multiply/divide datapath: operand capture, magnitude load,
// one shift-add or restoring-subtract step per cycle, and the final
// sign correction of the result.
// Signed handling is present only when MDU_SIGNED_EN is defined; otherwise
// operands are always treated as unsigned and no sign-fix logic exists.
module mdu_datapath
  import mdu_pkg::*;
#(
  parameter int DWL = DWL_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           prep,
  input  logic           step,
  input  logic           is_div,
`ifdef MDU_SIGNED_EN
  input  logic           is_signed,
`endif
  input  logic [DWL-1:0] src_a,
  input  logic [DWL-1:0] src_b,
  output logic [DWL-1:0] a_raw,
  output logic           b_zero,
  output logic [DWL-1:0] hi_res,
  output logic [DWL-1:0] lo_res
);

  logic [DWL-1:0] b_raw;
  logic [DWL-1:0] acc;       // partial product high half / partial remainder
  logic [DWL-1:0] quo;       // multiplier (shifts out) / quotient (shifts in)
  logic [DWL-1:0] mag;       // multiplicand or divisor magnitude
  logic [DWL-1:0] a_mag;
  logic [DWL-1:0] b_mag;
  logic [DWL:0]   mul_sum;
  logic [DWL:0]   div_sh;
  logic [DWL-1:0] div_diff;
  logic           div_ge;

`ifdef MDU_SIGNED_EN
  logic a_neg;
  logic b_neg;
  logic neg_q;               // sign of product / quotient
  logic neg_r;               // sign of remainder (follows the dividend)

  assign a_neg = is_signed & a_raw[DWL-1];
  assign b_neg = is_signed & b_raw[DWL-1];
  assign a_mag = a_neg ? -a_raw : a_raw;
  assign b_mag = b_neg ? -b_raw : b_raw;
`else
  assign a_mag = a_raw;
  assign b_mag = b_raw;
`endif

  assign b_zero   = (b_raw == '0);
  // Multiply: add the multiplicand when the multiplier LSB is set, then the
  // whole {acc,quo} pair shifts right by one.
  assign mul_sum  = {1'b0, acc} + (quo[0] ? {1'b0, mag} : '0);
  // Divide: shift the next dividend bit into the remainder and try a subtract.
  // While mag is non-zero the remainder stays below mag, so the difference
  // always fits in DWL bits when the subtract succeeds.
  assign div_sh   = {acc, quo[DWL-1]};
  assign div_ge   = (div_sh >= {1'b0, mag});
  assign div_diff = div_sh[DWL-1:0] - mag;

  // Operand capture on start, magnitude load in PREP, one step per CALC cycle.
  // NOTE: sequential state uses non-blocking (<=) assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_raw <= '0;
      b_raw <= '0;
      acc   <= '0;
      quo   <= '0;
      mag   <= '0;
    end else if (load) begin
      a_raw <= src_a;
      b_raw <= src_b;
    end else if (prep) begin
      acc <= '0;
      quo <= a_mag;
      mag <= b_mag;
    end else if (step) begin
      if (is_div) begin
        acc <= div_ge ? div_diff : div_sh[DWL-1:0];
        quo <= {quo[DWL-2:0], div_ge};
      end else begin
        acc <= mul_sum[DWL:1];
        quo <= {mul_sum[0], quo[DWL-1:1]};
      end
    end
  end

`ifdef MDU_SIGNED_EN
  logic [2*DWL-1:0] prod_mag;
  logic [2*DWL-1:0] prod;

  assign prod_mag = {acc, quo};
  assign prod     = neg_q ? -prod_mag : prod_mag;

  // Result signs recorded while the magnitudes are loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (prep) begin
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
    end
  end

  // Sign correction of the finished magnitude result.
  // NOTE: outputs get a default before any branch so no path leaves them
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    hi_res = acc;
    lo_res = quo;
    if (is_div) begin
      lo_res = neg_q ? -quo : quo;
      hi_res = neg_r ? -acc : acc;
    end else begin
      hi_res = prod[2*DWL-1:DWL];
      lo_res = prod[DWL-1:0];
    end
  end
`else
  assign hi_res = acc;
  assign lo_res = quo;
`endif

endmodule

// File: rtl/mdu_controller.sv
// Multiply/divide unit controller: sequencing FSM, iteration counter and the
// architectural HI/LO registers, around the iterative mdu_datapath.
// Latency is fixed: Done is high in the DWL+3rd cycle after the Start edge,
// including divide-by-zero. Define MDU_SIGNED_EN to make MULT/DIV signed;
// without it MULT behaves as MULTU and DIV as DIVU.
module mdu_controller
  import mdu_pkg::*;
#(
  parameter int DWL = DWL_DEFAULT,
  parameter int CWL = 6
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           Start,
  input  logic [1:0]     Op,
  input  logic [DWL-1:0] SrcA,
  input  logic [DWL-1:0] SrcB,
  input  logic           HIWE,
  input  logic           LOWE,
  input  logic [DWL-1:0] WD,
  output logic           Busy,
  output logic           Done,
  output logic           DivZero,
  output logic [DWL-1:0] HI,
  output logic [DWL-1:0] LO
);

  state_e         state;
  op_e            op_q;
  logic [CWL-1:0] count;

  logic           load;
  logic           prep;
  logic           step;
  logic           is_div;
  logic [DWL-1:0] a_raw;
  logic           b_zero;
  logic [DWL-1:0] hi_res;
  logic [DWL-1:0] lo_res;
  logic           host_wr_ok;

  assign load       = (state == ST_IDLE) && Start;
  assign prep       = (state == ST_PREP);
  assign step       = (state == ST_CALC);
  assign is_div     = op_is_div(op_q);
  // Host writes are honoured only when no result write can happen, so the
  // FIX write always wins over HIWE/LOWE.
  assign host_wr_ok = (state == ST_IDLE) || (state == ST_DONE);

`ifdef MDU_SIGNED_EN
  logic is_signed;
  assign is_signed = op_is_signed(op_q);
`else
  // Signedness is irrelevant in this build; only the divide bit is decoded.
  logic unused_op_lsb;
  assign unused_op_lsb = op_q[0];
`endif

  mdu_datapath #(
    .DWL(DWL)
  ) u_datapath (
    .clk      (CLK),
    .rst_n    (RST),
    .load     (load),
    .prep     (prep),
    .step     (step),
    .is_div   (is_div),
`ifdef MDU_SIGNED_EN
    .is_signed(is_signed),
`endif
    .src_a    (SrcA),
    .src_b    (SrcB),
    .a_raw    (a_raw),
    .b_zero   (b_zero),
    .hi_res   (hi_res),
    .lo_res   (lo_res)
  );

  // Sequencing FSM with registered Busy/Done/DivZero and HI/LO updates.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= ST_IDLE;
      op_q    <= OP_MULT;
      count   <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            op_q  <= op_e'(Op);
            Busy  <= 1'b1;
            state <= ST_PREP;
          end
        end
        ST_PREP: begin
          count <= CWL'(DWL);
          state <= ST_CALC;
        end
        ST_CALC: begin
          count <= count - CWL'(1);
          if (count == CWL'(1)) state <= ST_FIX;
        end
        ST_FIX: begin
          Busy  <= 1'b0;
          Done  <= 1'b1;
          state <= ST_DONE;
          if (is_div && b_zero) begin
            HI      <= a_raw;
            LO      <= '1;
            DivZero <= 1'b1;
          end else begin
            HI      <= hi_res;
            LO      <= lo_res;
            DivZero <= 1'b0;
          end
        end
        ST_DONE: begin
          Done    <= 1'b0;
          DivZero <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          Done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase

      if (host_wr_ok) begin
        if (HIWE) HI <= WD;
        if (LOWE) LO <= WD;
      end
    end
  end

endmodule

// File: tb/tb_mdu_controller.sv
// Directed testbench for mdu_controller (DWL=32). Expected results are
// hand-computed constants; signed expectations follow MDU_SIGNED_EN.
module tb_mdu_controller;

  localparam int DWL       = 32;
  localparam int DONE_EDGE = 34;  // Done seen after the 34th edge past Start = cycle 35

  logic            CLK = 1'b0;
  logic            RST;
  logic            Start;
  logic [1:0]      Op;
  logic [DWL-1:0]  SrcA, SrcB, WD;
  logic            HIWE, LOWE;
  logic            Busy, Done, DivZero;
  logic [DWL-1:0]  HI, LO;

  int n_cmp = 0;
  int n_bad = 0;

  // Results of the most recent run_op.
  logic [DWL-1:0] r_hi, r_lo, r_hi_mid, r_lo_mid;
  logic           r_dz, r_busy_prep, r_busy_done;
  int             r_done_edge, r_done_cnt;

  mdu_controller #(.DWL(DWL), .CWL(6)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
    .HIWE(HIWE), .LOWE(LOWE), .WD(WD), .Busy(Busy), .Done(Done),
    .DivZero(DivZero), .HI(HI), .LO(LO)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one operation and watch 40 edges; optionally inject a Start and
  // HIWE/LOWE write (WD=0x1234) sampled at edge inject_at while busy.
  task automatic run_op(input logic [1:0] op, input logic [DWL-1:0] a, input logic [DWL-1:0] b,
                        input int inject_at);
    r_hi = '0; r_lo = '0; r_dz = 1'b0; r_busy_done = 1'b1;
    r_hi_mid = '0; r_lo_mid = '0;
    r_done_edge = -1; r_done_cnt = 0;
    @(negedge CLK);
    Start = 1'b1; Op = op; SrcA = a; SrcB = b;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0; SrcA = '0; SrcB = '0;
    r_busy_prep = Busy;
    for (int n = 1; n <= 40; n++) begin
      if (n == inject_at) begin
        Start = 1'b1; Op = 2'b11; SrcA = 32'd50; SrcB = 32'd5;
        HIWE = 1'b1; LOWE = 1'b1; WD = 32'h1234;
      end
      @(posedge CLK);
      @(negedge CLK);
      Start = 1'b0; HIWE = 1'b0; LOWE = 1'b0;
      if (n == inject_at) begin r_hi_mid = HI; r_lo_mid = LO; end
      if (Done === 1'b1) begin
        r_done_cnt++;
        if (r_done_edge < 0) begin
          r_done_edge = n; r_hi = HI; r_lo = LO; r_dz = DivZero; r_busy_done = Busy;
        end
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if ({Busy, Done, DivZero} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000", {Busy, Done, DivZero});
    end
    n_cmp++;
    if ({HI, LO} !== 64'h0) begin
      n_bad++; $display("FAIL reset_hilo: got %h want 0", {HI, LO});
    end
    @(posedge CLK);
    #2 RST = 1'b1;
  endtask

  task automatic test_multu;
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    n_cmp++;
    if (r_done_edge != DONE_EDGE) begin
      n_bad++; $display("FAIL multu_latency: got edge %0d want %0d", r_done_edge, DONE_EDGE);
    end
    n_cmp++;
    if (r_done_cnt != 1) begin
      n_bad++; $display("FAIL multu_done_width: got %0d want 1", r_done_cnt);
    end
    n_cmp++;
    if ({r_hi, r_lo} !== 64'hFFFF_FFFE_0000_0001) begin
      n_bad++; $display("FAIL multu_result: got %h want fffffffe00000001", {r_hi, r_lo});
    end
    n_cmp++;
    if ({r_busy_prep, r_busy_done, r_dz} !== 3'b100) begin
      n_bad++; $display("FAIL multu_busy: got prep/done/dz %b want 100", {r_busy_prep, r_busy_done, r_dz});
    end
    n_cmp++;
    if ({Busy, Done, HI, LO} !== {2'b00, 64'hFFFF_FFFE_0000_0001}) begin
      n_bad++; $display("FAIL multu_hold: got %b %h want idle with product held", {Busy, Done}, {HI, LO});
    end
  endtask

  task automatic test_mult;
    logic [2*DWL-1:0] exp_p;
`ifdef MDU_SIGNED_EN
    exp_p = 64'hFFFF_FFFF_FFFF_FFEB;
`else
    exp_p = 64'h0000_0006_FFFF_FFEB;
`endif
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0);
    n_cmp++;
    if ({r_hi, r_lo} !== exp_p) begin
      n_bad++; $display("FAIL mult_result: got %h want %h", {r_hi, r_lo}, exp_p);
    end
    n_cmp++;
    if (r_done_edge != DONE_EDGE) begin
      n_bad++; $display("FAIL mult_latency: got edge %0d want %0d", r_done_edge, DONE_EDGE);
    end
  endtask

  task automatic test_div;
    logic [2*DWL-1:0] exp_p;
    run_op(2'b11, 32'd100, 32'd7, 0);
    n_cmp++;
    if ({r_hi, r_lo, r_dz} !== {32'd2, 32'd14, 1'b0}) begin
      n_bad++; $display("FAIL divu_result: got hi %h lo %h dz %b want 2 14 0", r_hi, r_lo, r_dz);
    end
`ifdef MDU_SIGNED_EN
    exp_p = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
`else
    exp_p = {32'h0000_0001, 32'h7FFF_FFFC};
`endif
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    n_cmp++;
    if ({r_hi, r_lo} !== exp_p) begin
      n_bad++; $display("FAIL div_result: got %h want %h", {r_hi, r_lo}, exp_p);
    end
    n_cmp++;
    if (r_done_edge != DONE_EDGE) begin
      n_bad++; $display("FAIL div_latency: got edge %0d want %0d", r_done_edge, DONE_EDGE);
    end
  endtask

  task automatic test_div_zero;
    run_op(2'b11, 32'd100, 32'd0, 0);
    n_cmp++;
    if ({r_hi, r_lo, r_dz} !== {32'd100, 32'hFFFF_FFFF, 1'b1}) begin
      n_bad++; $display("FAIL divzero_u: got hi %h lo %h dz %b want 64 ffffffff 1", r_hi, r_lo, r_dz);
    end
    n_cmp++;
    if (r_done_edge != DONE_EDGE) begin
      n_bad++; $display("FAIL divzero_latency: got edge %0d want %0d", r_done_edge, DONE_EDGE);
    end
    n_cmp++;
    if (DivZero !== 1'b0) begin
      n_bad++; $display("FAIL divzero_clear: got %b want 0", DivZero);
    end
    run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 0);
    n_cmp++;
    if ({r_hi, r_lo, r_dz} !== {32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1}) begin
      n_bad++; $display("FAIL divzero_s: got hi %h lo %h dz %b want fffffffb ffffffff 1", r_hi, r_lo, r_dz);
    end
  endtask

  task automatic test_div_ovf;
    logic [2*DWL-1:0] exp_p;
`ifdef MDU_SIGNED_EN
    exp_p = {32'h0000_0000, 32'h8000_0000};
`else
    exp_p = {32'h8000_0000, 32'h0000_0000};
`endif
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    n_cmp++;
    if ({r_hi, r_lo, r_dz} !== {exp_p, 1'b0}) begin
      n_bad++; $display("FAIL div_ovf: got hi %h lo %h dz %b want %h dz 0", r_hi, r_lo, r_dz, exp_p);
    end
    n_cmp++;
    if ($isunknown({HI, LO, Busy, Done, DivZero})) begin
      n_bad++; $display("FAIL div_ovf_x: got %h %b want no X", {HI, LO}, {Busy, Done, DivZero});
    end
  endtask

  task automatic test_hi_write;
    @(negedge CLK);
    HIWE = 1'b1; WD = 32'h1234;
    @(posedge CLK);
    @(negedge CLK);
    HIWE = 1'b0;
    n_cmp++;
    if ({HI, LO} !== {32'h1234, exp_lo_after_ovf()}) begin
      n_bad++; $display("FAIL hiwe_idle: got %h want %h", {HI, LO}, {32'h1234, exp_lo_after_ovf()});
    end
    LOWE = 1'b1; WD = 32'h5678;
    @(posedge CLK);
    @(negedge CLK);
    LOWE = 1'b0;
    n_cmp++;
    if ({HI, LO} !== {32'h1234, 32'h5678}) begin
      n_bad++; $display("FAIL lowe_idle: got %h want 0000123400005678", {HI, LO});
    end
  endtask

  function automatic logic [DWL-1:0] exp_lo_after_ovf();
`ifdef MDU_SIGNED_EN
    return 32'h8000_0000;
`else
    return 32'h0000_0000;
`endif
  endfunction

  task automatic test_busy_ignore;
    run_op(2'b01, 32'd5, 32'd6, 5);
    n_cmp++;
    if ({r_hi_mid, r_lo_mid} !== {32'h1234, 32'h5678}) begin
      n_bad++; $display("FAIL busy_write_dropped: got %h want 0000123400005678", {r_hi_mid, r_lo_mid});
    end
    n_cmp++;
    if ({r_hi, r_lo} !== {32'd0, 32'd30}) begin
      n_bad++; $display("FAIL busy_start_ignored: got %h want 30", {r_hi, r_lo});
    end
    n_cmp++;
    if (r_done_cnt != 1 || r_done_edge != DONE_EDGE) begin
      n_bad++; $display("FAIL busy_done_count: got %0d at edge %0d want 1 at %0d", r_done_cnt, r_done_edge, DONE_EDGE);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge CLK);
    Start = 1'b1; Op = 2'b01; SrcA = 32'd3; SrcB = 32'd4;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
    repeat (10) @(negedge CLK);
    n_cmp++;
    if (Busy !== 1'b1) begin
      n_bad++; $display("FAIL midreset_busy_before: got %b want 1", Busy);
    end
    #1 RST = 1'b0;
    #1;
    n_cmp++;
    if ({Busy, Done, DivZero} !== 3'b000) begin
      n_bad++; $display("FAIL midreset_flags: got %b want 000", {Busy, Done, DivZero});
    end
    n_cmp++;
    if ({HI, LO} !== 64'h0) begin
      n_bad++; $display("FAIL midreset_hilo: got %h want 0", {HI, LO});
    end
    repeat (2) @(posedge CLK);
    #2 RST = 1'b1;
    run_op(2'b01, 32'd9, 32'd9, 0);
    n_cmp++;
    if ({r_hi, r_lo} !== {32'd0, 32'd81} || r_done_edge != DONE_EDGE) begin
      n_bad++; $display("FAIL midreset_restart: got %h edge %0d want 81 edge %0d", {r_hi, r_lo}, r_done_edge, DONE_EDGE);
    end
  endtask

  initial begin
    RST = 1'b0; Start = 1'b0; Op = 2'b00; SrcA = '0; SrcB = '0;
    HIWE = 1'b0; LOWE = 1'b0; WD = '0;
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_zero();
    test_div_ovf();
    test_hi_write();
    test_busy_ignore();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mdu_controller.md
MDU_CONTROLLER -- requirements
Module: mdu_controller

Interface
REQ-001 SHALL have parameter DWL, default 32: operand/result data width.
REQ-002 SHALL have parameter CWL, default 6: iteration counter width, at least log2(DWL)+1.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port Start, input, 1 bit: operation request, sampled only in IDLE.
REQ-006 SHALL have port Op, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 SHALL have ports SrcA and SrcB, input, DWL bits each: multiplicand/dividend and multiplier/divisor.
REQ-008 SHALL have ports HIWE and LOWE, input, 1 bit each, and WD, input, DWL bits: direct HI/LO write for MTHI/MTLO.
REQ-009 SHALL have port Busy, output, 1 bit: high in PREP, CALC and FIX.
REQ-010 SHALL have port Done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port DivZero, output, 1 bit: divisor-zero flag, valid with Done.
REQ-012 SHALL have ports HI and LO, output, DWL bits each: architectural result registers.

Function
REQ-013 SHALL implement the FSM IDLE->PREP->CALC->FIX->DONE->IDLE, with one state transition per clock edge except CALC.
REQ-014 SHALL leave IDLE for PREP when Start=1 is seen at a clock edge, latching Op, SrcA and SrcB; Start SHALL be ignored in every other state.
REQ-015 SHALL, in PREP, convert signed operands to magnitude, record the result signs and load the counter with DWL.
REQ-016 SHALL perform, in CALC, one shift-add (multiply) or restore-subtract (divide) step per cycle, decrementing the counter, and go to FIX when the counter reaches 1.
REQ-017 SHALL, in FIX, apply sign correction; multiply: {HI,LO} = 2*DWL-bit product; divide: LO = quotient, HI = remainder, with the remainder taking the dividend's sign.
REQ-018 SHALL write HI and LO at the edge leaving FIX; Done=1 for exactly the DONE cycle; the fixed latency is Done high in the DWL+3rd cycle after the Start edge.
REQ-019 SHALL handle divisor 0 as follows: LO = all-ones, HI = SrcA, DivZero=1 with Done; the FSM SHALL still take the full latency.
REQ-020 SHALL handle signed DIV of the most-negative value by -1 as follows: LO = 0x80000000 (DWL-scaled), HI = 0, DivZero=0.
REQ-021 SHALL let HIWE/LOWE write WD into HI/LO at the next edge only in IDLE or DONE; writes in other states SHALL be dropped.
REQ-022 SHALL give the FIX write priority over HIWE/LOWE at the same edge.
REQ-023 SHALL keep HI and LO unchanged, apart from REQ-018 and REQ-021, across operations.

Reset
REQ-024 SHALL, on RST=0, immediately force state IDLE, counter 0, Busy=0, Done=0, DivZero=0, HI=0, LO=0 and clear internal operand registers.
REQ-025 SHALL abandon an in-flight operation on reset mid-operation, with no HI/LO update and no Done.
REQ-026 SHALL, after RST deasserts, accept Start at the first rising edge.

Configuration
REQ-027 SHALL use macro MDU_SIGNED_EN: when defined, MULT/DIV are signed per REQ-015/017/020.
REQ-028 SHALL, when MDU_SIGNED_EN is undefined, execute MULT as MULTU and DIV as DIVU; REQ-020 does not apply, and the sign-fix logic is absent.

Structure
REQ-029 SHALL keep the Op encodings, FSM state encodings and the DWL default in shared package mdu_pkg.
REQ-030 SHALL split the iterative shift/subtract datapath (accumulator, operand registers, adder/subtractor) into sub-module mdu_datapath, with mdu_controller holding the FSM, counter and HI/LO.

Verification
REQ-031 SHALL cover MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, Done one cycle at the 35th cycle after Start.
REQ-032 SHALL cover MULT -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; and with MDU_SIGNED_EN undefined -> HI=0x00000006, LO=0xFFFFFFEB.
REQ-033 SHALL cover DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; and DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=100, DivZero=1.
REQ-034 SHALL cover DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, no X on any output.
REQ-035 SHALL cover a second Start pulsed while Busy -> ignored, and HIWE with WD=0x1234 while Busy -> HI unchanged; HIWE in IDLE -> HI=0x1234 next cycle.
REQ-036 SHALL cover RST=0 asserted mid-CALC -> Busy and Done drop immediately, HI/LO=0, and a new Start after release completes normally.
